// File: rtl/bp_pkg.sv
// Branch predictor package: counter encodings, counter constants, table entry
// layout and the saturating-counter step function shared by every BTB entry.
package bp_pkg;

    // Encodings of the classic 2-bit bimodal counter (MSB = predict taken).
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr2_e;

    // Initial and ceiling values for the default 2-bit counter.
    localparam logic [1:0] CTR_INIT = CTR_WT;
    localparam logic [1:0] CTR_MAX  = CTR_ST;

    // Entry layout for the default 32-bit PC configuration.
    localparam int unsigned XLEN_DEF = 32;
    typedef struct packed {
        logic                  valid;
        logic [XLEN_DEF-3:0]   tag;
        logic [XLEN_DEF-1:0]   target;
        logic [1:0]            ctr;
    } bp_entry_t;

    // Ceiling of a w-bit counter (w < 32).
    function automatic logic [31:0] ctr_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Weak-taken value of a w-bit counter: only the MSB set.
    function automatic logic [31:0] ctr_init(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    // One saturating step: +1 toward ceiling on taken, -1 toward 0 otherwise.
    function automatic logic [31:0] ctr_next(input logic [31:0] ctr,
                                             input logic        taken,
                                             input int unsigned w);
        logic [31:0] nxt;
        if (taken) begin
            if (ctr == ctr_max(w)) nxt = ctr;
            else                   nxt = ctr + 32'd1;
        end else begin
            if (ctr == 32'd0)      nxt = ctr;
            else                   nxt = ctr - 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Per-entry saturating direction counter. A load (fresh allocation) forces
// the weak-taken value; an update steps the counter toward the outcome.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int unsigned CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             upd,
    input  logic             taken,
    output logic [CTR_W-1:0] ctr
);

    logic [CTR_W-1:0] ctr_r;

    // Counter state: allocation has priority over a training update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_r <= {CTR_W{1'b0}};
        end else if (load) begin
            ctr_r <= CTR_W'(ctr_init(CTR_W));
        end else if (upd) begin
            ctr_r <= CTR_W'(ctr_next(32'(ctr_r), taken, CTR_W));
        end else begin
            ctr_r <= ctr_r;
        end
    end

    assign ctr = ctr_r;

endmodule

// File: rtl/npc_bpred_btb.sv
// Next-PC generator with a fully-associative BTB and per-entry saturating
// counters. Fetch lookup is combinational; EX resolution trains the table on
// the clock edge, so a same-cycle lookup sees the pre-update contents.
// Optional build macro: BP_PERF_CNT_EN enables resolved/mispredict counters.
module npc_bpred_btb
    import bp_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              CpuRst_n,
    input  logic [XLEN-1:0]   PCF,
    input  logic              JalD,
    input  logic [XLEN-1:0]   JalTarget,
    input  logic              JalrE,
    input  logic [XLEN-1:0]   JalrTarget,
    input  logic              BranchValidE,
    input  logic              BranchTakenE,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   BranchTargetE,
    input  logic              PredTakenE,
    input  logic [XLEN-1:0]   PredTargetE,
    output logic              PredTakenF,
    output logic [XLEN-1:0]   PredTargetF,
    output logic              MispredE,
    output logic [XLEN-1:0]   PC_In,
    output logic [PERF_W-1:0] BranchCnt,
    output logic [PERF_W-1:0] MispredCnt
);

    localparam int unsigned TAG_W = XLEN - 2;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    logic             valid_r [DEPTH];
    logic [TAG_W-1:0] tag_r   [DEPTH];
    logic [XLEN-1:0]  tgt_r   [DEPTH];
    logic [CTR_W-1:0] ctr_s   [DEPTH];
    logic [PTR_W-1:0] ptr_r;

    logic             hit_f_s, hit_e_s;
    logic [PTR_W-1:0] idx_f_s, idx_e_s;
    logic [DEPTH-1:0] load_s, upd_s;
    logic             mispred_s;

    // Two independent CAM searches: fetch PC and resolving EX PC.
    always_comb begin
        hit_f_s = 1'b0;
        idx_f_s = {PTR_W{1'b0}};
        hit_e_s = 1'b0;
        idx_e_s = {PTR_W{1'b0}};
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_r[i] && (tag_r[i] == PCF[XLEN-1:2])) begin
                hit_f_s = 1'b1;
                idx_f_s = PTR_W'(i);
            end else begin
                hit_f_s = hit_f_s;
            end
            if (valid_r[i] && (tag_r[i] == PCE[XLEN-1:2])) begin
                hit_e_s = 1'b1;
                idx_e_s = PTR_W'(i);
            end else begin
                hit_e_s = hit_e_s;
            end
        end
    end

    // Fetch prediction and EX misprediction; all forced quiet while in reset.
    always_comb begin
        if (CpuRst_n && hit_f_s) begin
            PredTakenF  = ctr_s[idx_f_s][CTR_W-1];
            PredTargetF = tgt_r[idx_f_s];
        end else begin
            PredTakenF  = 1'b0;
            PredTargetF = {XLEN{1'b0}};
        end
        mispred_s = CpuRst_n & BranchValidE &
                    ((PredTakenE != BranchTakenE) |
                     (BranchTakenE & (PredTargetE != BranchTargetE)));
        MispredE  = mispred_s;
    end

    // Next-PC redirect priority: JALR, mispredict, JAL, prediction, sequential.
    always_comb begin
        if (!CpuRst_n) begin
            PC_In = PCF + PC_STEP;
        end else if (JalrE) begin
            PC_In = JalrTarget;
        end else if (mispred_s) begin
            if (BranchTakenE) PC_In = BranchTargetE;
            else              PC_In = PCE + PC_STEP;
        end else if (JalD) begin
            PC_In = JalTarget;
        end else if (PredTakenF) begin
            PC_In = PredTargetF;
        end else begin
            PC_In = PCF + PC_STEP;
        end
    end

    // Per-entry strobes: train on hit, allocate the round-robin slot on taken miss.
    always_comb begin
        upd_s  = {DEPTH{1'b0}};
        load_s = {DEPTH{1'b0}};
        for (int i = 0; i < int'(DEPTH); i++) begin
            upd_s[i]  = BranchValidE & hit_e_s & (idx_e_s == PTR_W'(i));
            load_s[i] = BranchValidE & ~hit_e_s & BranchTakenE & (ptr_r == PTR_W'(i));
        end
    end

    // Table tags/targets and allocation pointer (oldest entry is the victim).
    always_ff @(posedge clk or negedge CpuRst_n) begin
        if (!CpuRst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                valid_r[i] <= 1'b0;
                tag_r[i]   <= {TAG_W{1'b0}};
                tgt_r[i]   <= {XLEN{1'b0}};
            end
            ptr_r <= {PTR_W{1'b0}};
        end else if (BranchValidE) begin
            if (hit_e_s) begin
                if (BranchTakenE) tgt_r[idx_e_s] <= BranchTargetE;
            end else if (BranchTakenE) begin
                valid_r[ptr_r] <= 1'b1;
                tag_r[ptr_r]   <= PCE[XLEN-1:2];
                tgt_r[ptr_r]   <= BranchTargetE;
                ptr_r          <= ptr_r + PTR_W'(1);
            end
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_ctr
        bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
            .clk   (clk),
            .rst_n (CpuRst_n),
            .load  (load_s[g]),
            .upd   (upd_s[g]),
            .taken (BranchTakenE),
            .ctr   (ctr_s[g])
        );
    end

`ifdef BP_PERF_CNT_EN
    logic [PERF_W-1:0] bcnt_r, mcnt_r;

    // Saturating performance counters for resolved and mispredicted branches.
    always_ff @(posedge clk or negedge CpuRst_n) begin
        if (!CpuRst_n) begin
            bcnt_r <= {PERF_W{1'b0}};
            mcnt_r <= {PERF_W{1'b0}};
        end else begin
            if (BranchValidE && (bcnt_r != {PERF_W{1'b1}})) bcnt_r <= bcnt_r + PERF_W'(1);
            if (mispred_s && (mcnt_r != {PERF_W{1'b1}}))    mcnt_r <= mcnt_r + PERF_W'(1);
        end
    end

    assign BranchCnt  = bcnt_r;
    assign MispredCnt = mcnt_r;
`else
    assign BranchCnt  = {PERF_W{1'b0}};
    assign MispredCnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_npc_bpred_btb.sv
// Scoreboard bench for npc_bpred_btb: the driver computes expected outputs
// from a table-level reference model and queues them; the monitor compares
// on the falling edge.
module tb_npc_bpred_btb;

    localparam int DEPTH = 8;
    localparam int CTR_W = 2;
    localparam int CMAX  = 3;
    localparam int CINIT = 2;
`ifdef BP_PERF_CNT_EN
    localparam int PERF_W = 4;
`else
    localparam int PERF_W = 32;
`endif

    logic              clk = 1'b0;
    logic              CpuRst_n;
    logic [31:0]       PCF, JalTarget, JalrTarget, PCE, BranchTargetE, PredTargetE;
    logic              JalD, JalrE, BranchValidE, BranchTakenE, PredTakenE;
    logic              PredTakenF, MispredE;
    logic [31:0]       PredTargetF, PC_In;
    logic [PERF_W-1:0] BranchCnt, MispredCnt;

    npc_bpred_btb #(.XLEN(32), .DEPTH(DEPTH), .CTR_W(CTR_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .CpuRst_n(CpuRst_n), .PCF(PCF), .JalD(JalD), .JalTarget(JalTarget),
        .JalrE(JalrE), .JalrTarget(JalrTarget), .BranchValidE(BranchValidE),
        .BranchTakenE(BranchTakenE), .PCE(PCE), .BranchTargetE(BranchTargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .PredTakenF(PredTakenF),
        .PredTargetF(PredTargetF), .MispredE(MispredE), .PC_In(PC_In),
        .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic [31:0] pcf;
        logic        jald;
        logic [31:0] jalt;
        logic        jalre;
        logic [31:0] jalrt;
        logic        bv;
        logic        bt;
        logic [31:0] pce;
        logic [31:0] btgt;
        logic        pte;
        logic [31:0] ptgt;
    } stim_t;

    typedef struct packed {
        logic        ptf;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] pcin;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: map from word address to target/counter, plus allocation order.
    logic [31:0] m_tgt [logic [29:0]];
    int          m_ctr [logic [29:0]];
    logic [29:0] m_order[$];
    longint      m_bcnt, m_mcnt;
    longint      pmax = (64'd1 << PERF_W) - 64'd1;

    function automatic void model_reset();
        m_tgt.delete();
        m_ctr.delete();
        m_order.delete();
        m_bcnt = 0;
        m_mcnt = 0;
    endfunction

    function automatic void model_train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        logic [29:0] k = pc[31:2];
        if (m_ctr.exists(k)) begin
            if (taken) begin
                m_ctr[k] = (m_ctr[k] == CMAX) ? CMAX : m_ctr[k] + 1;
                m_tgt[k] = tgt;
            end else begin
                m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
            end
        end else if (taken) begin
            if (m_order.size() == DEPTH) begin
                logic [29:0] old = m_order.pop_front();
                m_ctr.delete(old);
                m_tgt.delete(old);
            end
            m_order.push_back(k);
            m_ctr[k] = CINIT;
            m_tgt[k] = tgt;
        end
    endfunction

    function automatic void model_pred(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        logic [29:0] k = pc[31:2];
        t = 1'b0;
        tg = 32'h0;
        if (m_ctr.exists(k)) begin
            t  = (m_ctr[k] >= CINIT);
            tg = m_tgt[k];
        end
    endfunction

    function automatic stim_t idle(input logic [31:0] pc);
        stim_t s = '0;
        s.rst_n = 1'b1;
        s.pcf   = pc;
        return s;
    endfunction

    // Apply one cycle of stimulus, queue the expected response, advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        logic pt;
        logic [31:0] ptg;
        @(posedge clk);
        #1;
        CpuRst_n = s.rst_n; PCF = s.pcf; JalD = s.jald; JalTarget = s.jalt;
        JalrE = s.jalre; JalrTarget = s.jalrt; BranchValidE = s.bv;
        BranchTakenE = s.bt; PCE = s.pce; BranchTargetE = s.btgt;
        PredTakenE = s.pte; PredTargetE = s.ptgt;
        if (!s.rst_n) model_reset();
        model_pred(s.pcf, pt, ptg);
        e.ptf  = s.rst_n & pt;
        e.ptgt = s.rst_n ? ptg : 32'h0;
        e.mis  = s.rst_n && s.bv && ((s.pte != s.bt) || (s.bt && (s.ptgt != s.btgt)));
        if (!s.rst_n)     e.pcin = s.pcf + 32'd4;
        else if (s.jalre) e.pcin = s.jalrt;
        else if (e.mis)   e.pcin = s.bt ? s.btgt : s.pce + 32'd4;
        else if (s.jald)  e.pcin = s.jalt;
        else if (e.ptf)   e.pcin = e.ptgt;
        else              e.pcin = s.pcf + 32'd4;
        e.bcnt = 32'(m_bcnt);
        e.mcnt = 32'(m_mcnt);
        exp_q.push_back(e);
        if (s.rst_n) begin
`ifdef BP_PERF_CNT_EN
            if (s.bv && m_bcnt < pmax) m_bcnt++;
            if (e.mis && m_mcnt < pmax) m_mcnt++;
`endif
            if (s.bv) model_train(s.pce, s.bt, s.btgt);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every queued expectation against the DUT on the falling edge.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("PredTakenF",  32'(PredTakenF), 32'(mon_e.ptf));
                chk("PredTargetF", PredTargetF,     mon_e.ptgt);
                chk("MispredE",    32'(MispredE),   32'(mon_e.mis));
                chk("PC_In",       PC_In,           mon_e.pcin);
                chk("BranchCnt",   32'(BranchCnt),  mon_e.bcnt);
                chk("MispredCnt",  32'(MispredCnt), mon_e.mcnt);
            end
        end
    end

    function automatic logic [31:0] rand_pc();
        return 32'h1000 + $urandom_range(0, 15) * 32'd4;
    endfunction

    initial begin
        stim_t s;
        logic  pt;
        logic [31:0] ptg;
        int    waitc;
        CpuRst_n = 1'b0; PCF = 32'h0; JalD = 1'b0; JalTarget = 32'h0; JalrE = 1'b0;
        JalrTarget = 32'h0; BranchValidE = 1'b0; BranchTakenE = 1'b0; PCE = 32'h0;
        BranchTargetE = 32'h0; PredTakenE = 1'b0; PredTargetE = 32'h0;
        model_reset();

        // Reset with PCF=0x100, then idle.
        s = idle(32'h100); s.rst_n = 1'b0;
        step(s); step(s);
        step(idle(32'h100));

        // Taken branch at 0x20 not predicted; same-cycle lookup still misses.
        s = idle(32'h20); s.bv = 1'b1; s.bt = 1'b1; s.pce = 32'h20; s.btgt = 32'h80;
        step(s);
        step(idle(32'h20));

        // Two not-taken resolutions walk the counter down to strongly not-taken.
        s = idle(32'h24); s.bv = 1'b1; s.pce = 32'h20; s.pte = 1'b1; s.ptgt = 32'h80;
        step(s);
        s.pte = 1'b0; s.ptgt = 32'h0;
        step(s);
        step(idle(32'h20));

        // Saturation at the top and bottom of the counter.
        for (int i = 0; i < 5; i++) begin
            s = idle(32'h40); s.bv = 1'b1; s.bt = 1'b1; s.pce = 32'h40; s.btgt = 32'h90;
            model_pred(32'h40, pt, ptg); s.pte = pt; s.ptgt = ptg;
            step(s);
        end
        for (int i = 0; i < 5; i++) begin
            s = idle(32'h40); s.bv = 1'b1; s.pce = 32'h40;
            model_pred(32'h40, pt, ptg); s.pte = pt; s.ptgt = ptg;
            step(s);
        end
        step(idle(32'h40));

        // Fill beyond capacity: the first allocation is evicted.
        s = idle(32'h0); s.rst_n = 1'b0; step(s);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            s = idle(32'h0); s.bv = 1'b1; s.bt = 1'b1;
            s.pce = 32'(i) * 32'h10; s.btgt = 32'h400 + 32'(i) * 32'd4;
            step(s);
        end
        for (int i = 1; i <= DEPTH + 1; i++) step(idle(32'(i) * 32'h10));

        // Redirect priority: JALR over mispredict over JAL.
        s = idle(32'h200); s.jalre = 1'b1; s.jalrt = 32'h500; s.jald = 1'b1; s.jalt = 32'h700;
        s.bv = 1'b1; s.bt = 1'b1; s.pce = 32'h30; s.btgt = 32'h600;
        step(s);
        s.jalre = 1'b0; s.pce = 32'h34;
        step(s);
        s.bv = 1'b0;
        step(s);

        // PC wrap on the sequential path.
        step(idle(32'hFFFF_FFFC));

        // Twenty mispredicted branches, then reset mid-run.
        for (int i = 0; i < 20; i++) begin
            s = idle(32'h300); s.bv = 1'b1; s.pce = 32'h800 + 32'(i) * 32'd4; s.pte = 1'b1;
            s.ptgt = 32'h900;
            step(s);
        end
        step(idle(32'h300));
        s = idle(32'h300); s.rst_n = 1'b0; s.bv = 1'b1; s.bt = 1'b1; s.pce = 32'h300;
        step(s);
        step(idle(32'h300));

        // Randomized traffic over a small PC pool to exercise hits and eviction.
        for (int n = 0; n < 3000; n++) begin
            s = idle(rand_pc());
            s.rst_n = ($urandom_range(0, 299) != 0);
            s.jald  = ($urandom_range(0, 7) == 0);
            s.jalt  = 32'h4000 + $urandom_range(0, 255) * 32'd4;
            s.jalre = ($urandom_range(0, 9) == 0);
            s.jalrt = 32'h5000 + $urandom_range(0, 255) * 32'd4;
            s.bv    = ($urandom_range(0, 1) == 1);
            s.bt    = ($urandom_range(0, 1) == 1);
            s.pce   = ($urandom_range(0, 3) == 0) ? s.pcf : rand_pc();
            s.btgt  = 32'h2000 + $urandom_range(0, 3) * 32'd4;
            model_pred(s.pce, pt, ptg);
            if ($urandom_range(0, 3) != 0) begin
                s.pte = pt; s.ptgt = ptg;
            end else begin
                s.pte = ($urandom_range(0, 1) == 1);
                s.ptgt = 32'h2000 + $urandom_range(0, 3) * 32'd4;
            end
            step(s);
        end

        waitc = 0;
        while (exp_q.size() > 0 && waitc < 10) begin
            @(posedge clk);
            waitc++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
